encoder_8x3_sync: RTL
=====================

ENCODER_8X3_SYNC -- requirements
Module: encoder_8x3_sync

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 D  input  8  request lines; index i = request i; D[7] highest priority.
REQ-005 ack  input  1  consumer accepts the presented code; meaningful only while valid=1.
REQ-006 x  output  1  code bit 2 (MSB) of the granted index.
REQ-007 y  output  1  code bit 1 of the granted index.
REQ-008 z  output  1  code bit 0 (LSB) of the granted index; {x,y,z} is the inverse of the team's 3x8 decoder mapping.
REQ-009 valid  output  1  {x,y,z} holds a granted request awaiting ack.
REQ-010 pending  output  8  captured, not yet acknowledged requests.
REQ-011 overrun  output  1  sticky: a request was lost because its bit was already pending.

Function
REQ-012 Request capture SHALL be rising-edge based: edge[i] = D[i] & ~D_q[i], where D_q is D registered each cycle; a held-high D[i] SHALL produce exactly one event.
REQ-013 Each cycle pending SHALL update as pending <= (pending & ~clr) | edge, where clr is the one-hot bit of the current code when valid=1 and ack=1, else 0.
REQ-014 When edge[i]=1 and clr[i]=1 in the same cycle, set SHALL win: pending[i] stays 1 and no overrun is flagged.
REQ-015 When edge[i]=1 while pending[i]=1 and clr[i]=0, overrun SHALL go to 1 on that edge and stay 1 until rst.
REQ-016 FSM states: IDLE (valid=0), HOLD (valid=1); no other states.
REQ-017 IDLE -> HOLD when registered pending != 0; on that edge {x,y,z} SHALL load the highest set index of pending.
REQ-018 HOLD -> IDLE when ack=1 on a clock edge; on that edge the granted pending bit is cleared and valid falls.
REQ-019 In HOLD, {x,y,z} SHALL remain stable regardless of new higher-priority requests; re-prioritisation occurs only at the next grant.
REQ-020 ack while IDLE SHALL be ignored and SHALL NOT modify pending.
REQ-021 Latency: edge on D[i] sampled at edge k -> pending[i]=1 after k -> valid=1 with code i after k+1 (if IDLE and i is highest).
REQ-022 Back-to-back grants SHALL be separated by at least one cycle with valid=0.
REQ-023 In IDLE, {x,y,z} SHALL hold their last granted value (000 after reset).

Reset
REQ-024 On rst=1 at a clock edge: state=IDLE, valid=0, {x,y,z}=000, pending=00000000, overrun=0, D_q=00000000.
REQ-025 rst SHALL take priority over all other inputs, including mid-HOLD and simultaneous ack; an outstanding grant is discarded.
REQ-026 A D[i] held high across reset release SHALL register as one new event on the first cycle after reset.

Verification
REQ-027 Single request: D=00001000 one cycle -> pending=00001000 next cycle, then valid=1, {x,y,z}=011; ack=1 one cycle -> valid=0, pending=00000000.
REQ-028 Priority: D=10000101 in one cycle -> grants in order 111, 010, 000 with ack each, one valid=0 cycle between grants.
REQ-029 Stability: in HOLD with code 001, pulse D[6] -> code stays 001 until ack; next grant is 110.
REQ-030 Overrun/set-wins: pulse D[2] twice before ack -> overrun=1; separately, re-pulse D[5] in the ack cycle of grant 101 -> pending[5]=1, overrun unchanged, 101 granted again.
REQ-031 Held input: D=00000001 held 20 cycles with acks -> exactly one grant of 000.
REQ-032 Reset mid-HOLD: valid=1, pending=00110000, assert rst with ack=1 -> all outputs reset per REQ-024; no grant appears afterwards unless D edges or is held high per REQ-026.

Source files
------------

// File: rtl/encoder_8x3_sync.sv
// Edge-captured 8-request priority encoder with a valid/ack handshake.
// Requests latch into a pending set; the highest is granted as {x,y,z}, held until ack, then cleared.
module encoder_8x3_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] D,
  input  logic       ack,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_d_q;
  logic [7:0] r_pending;
  logic [7:0] w_edge;
  logic [7:0] w_clr;
  logic [7:0] w_pending_nxt;
  logic [2:0] r_code;
  logic [2:0] w_code_nxt;
  logic [2:0] w_top;
  logic       r_overrun;
  logic       w_lost;

  assign w_edge        = D & ~r_d_q;
  assign w_clr         = (r_state == HOLD && ack) ? (8'b1 << r_code) : 8'b0;
  // A new edge wins over a same-cycle clear, so it is only "lost" when no clear was due.
  assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;
  assign w_lost        = |(w_edge & r_pending & ~w_clr);

  always_comb begin
    w_top = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pending[i]) w_top = 3'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_state_nxt = HOLD;
          w_code_nxt  = w_top;
        end
      end
      HOLD: begin
        if (ack) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_code    <= 3'd0;
      r_pending <= 8'd0;
      r_overrun <= 1'b0;
      r_d_q     <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_pending <= w_pending_nxt;
      r_overrun <= r_overrun | w_lost;
      r_d_q     <= D;
    end
  end

  assign x       = r_code[2];
  assign y       = r_code[1];
  assign z       = r_code[0];
  assign valid   = (r_state == HOLD);
  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule
